stopwatch_disp_scan: RTL and testbench

- Downstream consumer of the stopwatch counter block. Takes its minute, second and centisecond binary outputs and drives a 6-digit multiplexed 7-segment display showing MM.SS.CC.
- Provides a lap/hold function that freezes the display while the counter keeps running.
- Converts binary to BCD, clamps out-of-range values, and scans digits at a divided rate.

---
 rtl/stopwatch_disp_scan.sv | 181 ++++++++++++++++++
 tb/tb_stopwatch_disp_scan.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_disp_scan.sv
// Six-digit multiplexed 7-segment driver for the stopwatch (MM.SS.CC).
// Snapshot/lap-hold, clamp, BCD and digit scan, all registered.
module stopwatch_disp_scan #(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] secv100,
  input  logic       lap,
  output logic       held,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned NDIG    = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NDIG - 1);

  localparam logic [5:0] AN_OFF  = SEG_ACT_LOW ? 6'h3F : 6'h00;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACT_LOW ? 1'b1  : 1'b0;

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [5:0] mm;
    logic [5:0] ss;
    logic [6:0] cc;
  } time_t;

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] bcd_units(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  // Active-high gfedcba pattern.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  state_e                    state_q, state_d;
  logic                      lap_q;
  logic                      lap_edge_c;
  time_t                     snap_q, snap_d;
  time_t                     clamp_q, clamp_d;
  logic [NDIG-1:0][3:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      held_q, held_d;
  logic [5:0]                an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;

  assign lap_edge_c = lap & ~lap_q;

  // Lap/hold FSM: LIVE tracks the counter, HOLD freezes the snapshot.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    case (state_q)
      ST_LIVE: begin
        snap_d = {min, sec, secv100};
        if (lap_edge_c) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (lap_edge_c) state_d = ST_LIVE;
      end
      default: state_d = ST_LIVE;
    endcase
    held_d = (state_d == ST_HOLD);
  end

  // Clamp the counter's transient 60/100 terminal values.
  always_comb begin
    clamp_d    = snap_q;
    clamp_d.mm = (snap_q.mm > 6'd59) ? 6'd59 : snap_q.mm;
    clamp_d.ss = (snap_q.ss > 6'd59) ? 6'd59 : snap_q.ss;
    clamp_d.cc = (snap_q.cc > 7'd99) ? 7'd99 : snap_q.cc;
  end

  always_comb begin
    bcd_d = {bcd_tens(7'(clamp_q.mm)), bcd_units(7'(clamp_q.mm)),
             bcd_tens(7'(clamp_q.ss)), bcd_units(7'(clamp_q.ss)),
             bcd_tens(clamp_q.cc),     bcd_units(clamp_q.cc)};
  end

  // Digit scan: index walks 5..0 once per SCAN_DIV cycles.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
    end
  end

  // Output encode; minute tens is blanked when zero.
  always_comb begin
    logic [3:0] digit;
    logic [5:0] an_act;
    logic [6:0] seg_act;
    logic       dp_act;
    digit = 4'd0;
    case (idx_q)
      3'd0:    digit = bcd_q[0];
      3'd1:    digit = bcd_q[1];
      3'd2:    digit = bcd_q[2];
      3'd3:    digit = bcd_q[3];
      3'd4:    digit = bcd_q[4];
      3'd5:    digit = bcd_q[5];
      default: digit = 4'd0;
    endcase
    an_act  = 6'd1 << idx_q;
    seg_act = seg_code(digit);
    if ((idx_q == IDX_TOP) && (digit == 4'd0)) seg_act = 7'h00;
    dp_act  = (idx_q == 3'd4) || (idx_q == 3'd2);
    an_d    = SEG_ACT_LOW ? ~an_act  : an_act;
    seg_d   = SEG_ACT_LOW ? ~seg_act : seg_act;
    dp_d    = SEG_ACT_LOW ? ~dp_act  : dp_act;
  end

  // lap_q follows lap even in reset so a level held across reset is no edge.
  always_ff @(posedge clk) begin
    lap_q <= lap;
    if (res) begin
      state_q <= ST_LIVE;
      snap_q  <= '0;
      clamp_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= IDX_TOP;
      held_q  <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      clamp_q <= clamp_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      held_q  <= held_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign held = held_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_stopwatch_disp_scan.sv
// Directed bench for stopwatch_disp_scan: one active-low and one active-high instance.
module tb_stopwatch_disp_scan;

  logic       clk = 1'b0;
  logic       res;
  logic       lap;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] secv100;

  logic       held_al, held_ah;
  logic [5:0] an_al, an_ah;
  logic [6:0] seg_al, seg_ah;
  logic       dp_al, dp_ah;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_disp_scan #(.SCAN_DIV(4), .SEG_ACT_LOW(1'b1)) u_dut_al (
    .clk(clk), .res(res), .min(min), .sec(sec), .secv100(secv100), .lap(lap),
    .held(held_al), .an(an_al), .seg(seg_al), .dp(dp_al)
  );

  stopwatch_disp_scan #(.SCAN_DIV(4), .SEG_ACT_LOW(1'b0)) u_dut_ah (
    .clk(clk), .res(res), .min(min), .sec(sec), .secv100(secv100), .lap(lap),
    .held(held_ah), .an(an_ah), .seg(seg_ah), .dp(dp_ah)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_time(input int m, input int s, input int c);
    min     = 6'(m);
    sec     = 6'(s);
    secv100 = 7'(c);
  endtask

  task automatic wait_an(input string tag, input logic [5:0] target);
    int n;
    n = 0;
    while (an_ah !== target && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(an_ah), 32'(target));
  endtask

  // Align to the start of digit 5's slot, then check all six slots.
  task automatic scan_check(input string tag, input logic [5:0][6:0] exp_seg);
    wait_an({tag, "_sync01"}, 6'h01);
    wait_an({tag, "_sync20"}, 6'h20);
    for (int d = 5; d >= 0; d--) begin
      logic [5:0] a, a_n;
      logic [6:0] s, s_n;
      logic       p, p_n;
      a   = 6'd1 << d;
      a_n = ~a;
      s   = exp_seg[d];
      s_n = ~s;
      p   = (d == 4) || (d == 2);
      p_n = ~p;
      check($sformatf("%s_an_ah%0d", tag, d),  32'(an_ah),  32'(a));
      check($sformatf("%s_seg_ah%0d", tag, d), 32'(seg_ah), 32'(s));
      check($sformatf("%s_dp_ah%0d", tag, d),  32'(dp_ah),  32'(p));
      check($sformatf("%s_an_al%0d", tag, d),  32'(an_al),  32'(a_n));
      check($sformatf("%s_seg_al%0d", tag, d), 32'(seg_al), 32'(s_n));
      check($sformatf("%s_dp_al%0d", tag, d),  32'(dp_al),  32'(p_n));
      repeat (4) tick();
    end
  endtask

  initial begin
    int toggles;
    logic prev;

    res = 1'b1;
    lap = 1'b0;
    set_time(0, 0, 0);

    // Reset state
    repeat (3) tick();
    check("rst_an_al",   32'(an_al),   32'(6'h3F));
    check("rst_seg_al",  32'(seg_al),  32'(7'h7F));
    check("rst_dp_al",   32'(dp_al),   32'(1'b1));
    check("rst_held_al", 32'(held_al), 32'(1'b0));
    check("rst_an_ah",   32'(an_ah),   32'(6'h00));
    check("rst_seg_ah",  32'(seg_ah),  32'(7'h00));

    res = 1'b0;
    tick();
    check("first_an_al",  32'(an_al),  32'(6'h1F));
    check("first_an_ah",  32'(an_ah),  32'(6'h20));
    check("first_seg_ah", 32'(seg_ah), 32'(7'h00));

    // Live display 12:34.56
    set_time(12, 34, 56);
    repeat (4) tick();
    scan_check("live", {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D});

    // Leading-zero blank and clamp 05:60.100 -> 05:59.99
    set_time(5, 60, 100);
    repeat (4) tick();
    scan_check("clamp", {7'h00, 7'h6D, 7'h6D, 7'h6F, 7'h6F, 7'h6F});

    // Minute clamp 60:00.127 -> 59:00.99
    set_time(60, 0, 127);
    repeat (4) tick();
    scan_check("clamp2", {7'h6D, 7'h6F, 7'h3F, 7'h3F, 7'h6F, 7'h6F});

    // Hold: lap edge coincides with change to 07.42, which must be captured
    set_time(0, 7, 41);
    repeat (4) tick();
    lap = 1'b1;
    set_time(0, 7, 42);
    tick();
    lap = 1'b0;
    set_time(0, 8, 0);
    repeat (2) tick();
    check("hold_held_ah", 32'(held_ah), 32'(1'b1));
    check("hold_held_al", 32'(held_al), 32'(1'b1));
    scan_check("hold", {7'h00, 7'h3F, 7'h3F, 7'h07, 7'h66, 7'h5B});

    lap = 1'b1;
    tick();
    lap = 1'b0;
    tick();
    check("unhold_held", 32'(held_ah), 32'(1'b0));
    scan_check("unhold", {7'h00, 7'h3F, 7'h3F, 7'h7F, 7'h3F, 7'h3F});

    // Level lap: 50 cycles high gives exactly one toggle
    toggles = 0;
    prev = held_ah;
    lap = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (held_ah !== prev) toggles++;
      prev = held_ah;
    end
    check("level_toggles", 32'(toggles), 32'd1);
    check("level_held",    32'(held_ah), 32'(1'b1));

    // lap and res together: res wins, no toggle after release with lap high
    res = 1'b1;
    tick();
    check("lapres_held", 32'(held_ah), 32'(1'b0));
    res = 1'b0;
    toggles = 0;
    prev = held_ah;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (held_ah !== prev) toggles++;
      prev = held_ah;
    end
    check("lapres_toggles", 32'(toggles), 32'd0);
    check("lapres_held2",   32'(held_ah), 32'(1'b0));
    lap = 1'b0;
    tick();

    // Reset mid-HOLD at index 2
    set_time(12, 34, 56);
    repeat (4) tick();
    lap = 1'b1;
    tick();
    lap = 1'b0;
    set_time(23, 45, 7);
    tick();
    check("midhold_held", 32'(held_ah), 32'(1'b1));
    wait_an("midhold_idx2", 6'h04);
    res = 1'b1;
    tick();
    check("midhold_rst_held", 32'(held_ah), 32'(1'b0));
    check("midhold_rst_an",   32'(an_ah),   32'(6'h00));
    check("midhold_rst_anal", 32'(an_al),   32'(6'h3F));
    res = 1'b0;
    tick();
    check("midhold_rel_an",  32'(an_ah),  32'(6'h20));
    check("midhold_rel_seg", 32'(seg_ah), 32'(7'h00));
    scan_check("midhold_live", {7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h07});
    check("midhold_held2", 32'(held_ah), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
